// File: rtl/best_nbr_pkg.sv
// -----------------------------------------------------------------------------
// best_nbr_pkg
// Shared definitions for the best-neighbour table scanner.
//   - state_e     : scanner FSM state encoding
//   - MODE_*      : ordering selectors (Q-first / hops-first)
//   - CNT_OFS     : offset of the count word from the table base address
//   - ENTRY_WORDS : words per table entry ({ID, hops, Q})
// No ports (package).
// -----------------------------------------------------------------------------
package best_nbr_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_RD_CNT  = 4'd1,
    ST_CAP_CNT = 4'd2,
    ST_RD_ID   = 4'd3,
    ST_CAP_ID  = 4'd4,
    ST_RD_HOP  = 4'd5,
    ST_CAP_HOP = 4'd6,
    ST_RD_Q    = 4'd7,
    ST_CAP_Q   = 4'd8,
    ST_CMP     = 4'd9,
    ST_DONE    = 4'd10
  } state_e;

  localparam logic MODE_QFIRST = 1'b0;
  localparam logic MODE_HFIRST = 1'b1;

  // Table layout: [base+CNT_OFS] = count, then count x {ID, hops, Q}.
  localparam int CNT_OFS     = 0;
  localparam int ENTRY_WORDS = 3;

endpackage

// File: rtl/nbr_better_cmp.sv
// -----------------------------------------------------------------------------
// nbr_better_cmp
// Combinational "strictly better" test of a candidate (Q, hops) against a
// reference (Q, hops). All compares are unsigned over the full width.
//   mode   : MODE_QFIRST -> higher Q wins, fewer hops breaks a Q tie
//            MODE_HFIRST -> fewer hops wins, higher Q breaks a hops tie
//   better : 1 when the candidate strictly beats the reference; a full tie
//            returns 0 so the earlier entry is kept.
// Ports: mode, cand_q, cand_h, ref_q, ref_h (in); better (out).
// -----------------------------------------------------------------------------
module nbr_better_cmp
  import best_nbr_pkg::*;
#(
  parameter int WORD_W = 16
) (
  input  logic              mode,
  input  logic [WORD_W-1:0] cand_q,
  input  logic [WORD_W-1:0] cand_h,
  input  logic [WORD_W-1:0] ref_q,
  input  logic [WORD_W-1:0] ref_h,
  output logic              better
);

  logic q_gt;
  logic q_eq;
  logic h_lt;
  logic h_eq;

  always_comb begin
    q_gt = (cand_q > ref_q);
    q_eq = (cand_q == ref_q);
    h_lt = (cand_h < ref_h);
    h_eq = (cand_h == ref_h);
    if (mode == MODE_QFIRST) begin
      better = q_gt | (q_eq & h_lt);
    end else begin
      better = h_lt | (h_eq & q_gt);
    end
  end

endmodule

// File: rtl/best_neighbor_scan.sv
// -----------------------------------------------------------------------------
// best_neighbor_scan
// On start, walks a neighbour table in node memory (count word followed by
// {ID, hops, Q} triplets) and reports the neighbour that best beats the node's
// own (Q, hops) baseline under the selected ordering.
//
// Memory handshake: every RD_x state drives rd_en=1 with address=pointer; the
// read data is valid on data_in in the following CAP_x state, which captures it
// and advances the pointer. There is no backpressure: memory must answer in
// exactly one cycle.
//
// Ports:
//   clock, nrst          : clock (rising edge), async active-low reset
//   en                   : block enable, low aborts to IDLE without done
//   start, mode          : scan request (IDLE only), ordering select
//   base_addr            : address of the count word
//   node_id              : own ID, matching entries are skipped
//   my_best_q, my_best_h : comparison baseline
//   data_in              : memory read data
//   address, rd_en       : memory read port
//   busy, done           : status, done is a one-cycle pulse
//   best_*               : winning neighbour (held until the next start)
//   nbr_count            : entries scanned after clamping to MAX_NBRS
//   cnt_clamped          : table count exceeded MAX_NBRS
// Optional (macro BEST_NBR_SECOND_EN): second_valid/second_nbr_id/second_hop/
//   second_q report the runner-up under the same ordering.
// -----------------------------------------------------------------------------
module best_neighbor_scan
  import best_nbr_pkg::*;
#(
  parameter int WORD_W   = 16,
  parameter int ADDR_W   = 11,
  parameter int MAX_NBRS = 32
) (
  input  logic                        clock,
  input  logic                        nrst,
  input  logic                        en,
  input  logic                        start,
  input  logic                        mode,
  input  logic [ADDR_W-1:0]           base_addr,
  input  logic [WORD_W-1:0]           node_id,
  input  logic [WORD_W-1:0]           my_best_q,
  input  logic [WORD_W-1:0]           my_best_h,
  input  logic [WORD_W-1:0]           data_in,
  output logic [ADDR_W-1:0]           address,
  output logic                        rd_en,
  output logic                        busy,
  output logic                        done,
  output logic                        best_valid,
  output logic [WORD_W-1:0]           best_nbr_id,
  output logic [WORD_W-1:0]           best_hop,
  output logic [WORD_W-1:0]           best_q,
  output logic [$clog2(MAX_NBRS):0]   nbr_count,
  output logic                        cnt_clamped
`ifdef BEST_NBR_SECOND_EN
  ,
  output logic                        second_valid,
  output logic [WORD_W-1:0]           second_nbr_id,
  output logic [WORD_W-1:0]           second_hop,
  output logic [WORD_W-1:0]           second_q
`endif
);

  localparam int CNT_W = $clog2(MAX_NBRS) + 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   last_addr_q, last_addr_d;
  logic                mode_q, mode_d;
  logic [WORD_W-1:0]   node_id_q, node_id_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                clamped_q, clamped_d;
  logic [WORD_W-1:0]   cand_id_q, cand_id_d;
  logic [WORD_W-1:0]   cand_h_q, cand_h_d;
  logic [WORD_W-1:0]   cand_q_q, cand_q_d;
  logic                best_valid_q, best_valid_d;
  logic [WORD_W-1:0]   best_id_q, best_id_d;
  logic [WORD_W-1:0]   best_h_q, best_h_d;
  logic [WORD_W-1:0]   best_qv_q, best_qv_d;
  logic                beats_best;
  logic                in_rd;

`ifdef BEST_NBR_SECOND_EN
  logic                sec_valid_q, sec_valid_d;
  logic [WORD_W-1:0]   sec_id_q, sec_id_d;
  logic [WORD_W-1:0]   sec_h_q, sec_h_d;
  logic [WORD_W-1:0]   sec_qv_q, sec_qv_d;
  logic                beats_second;

  nbr_better_cmp #(.WORD_W(WORD_W)) u_cmp_second (
    .mode   (mode_q),
    .cand_q (cand_q_q),
    .cand_h (cand_h_q),
    .ref_q  (sec_qv_q),
    .ref_h  (sec_h_q),
    .better (beats_second)
  );
`endif

  nbr_better_cmp #(.WORD_W(WORD_W)) u_cmp_best (
    .mode   (mode_q),
    .cand_q (cand_q_q),
    .cand_h (cand_h_q),
    .ref_q  (best_qv_q),
    .ref_h  (best_h_q),
    .better (beats_best)
  );

  // Read strobe and address are pure functions of the state register; the
  // address holds its last driven value outside the read states.
  always_comb begin
    in_rd = (state_q == ST_RD_CNT) || (state_q == ST_RD_ID) ||
            (state_q == ST_RD_HOP) || (state_q == ST_RD_Q);
    rd_en   = in_rd;
    address = in_rd ? ptr_q : last_addr_q;
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_DONE);
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    last_addr_d  = in_rd ? ptr_q : last_addr_q;
    mode_d       = mode_q;
    node_id_d    = node_id_q;
    idx_d        = idx_q;
    count_d      = count_q;
    clamped_d    = clamped_q;
    cand_id_d    = cand_id_q;
    cand_h_d     = cand_h_q;
    cand_q_d     = cand_q_q;
    best_valid_d = best_valid_q;
    best_id_d    = best_id_q;
    best_h_d     = best_h_q;
    best_qv_d    = best_qv_q;
`ifdef BEST_NBR_SECOND_EN
    sec_valid_d  = sec_valid_q;
    sec_id_d     = sec_id_q;
    sec_h_d      = sec_h_q;
    sec_qv_d     = sec_qv_q;
`endif

    if (!en) begin
      // Abort: back to IDLE with all results frozen and no done pulse.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mode_d       = mode;
            ptr_d        = base_addr + ADDR_W'(CNT_OFS);
            node_id_d    = node_id;
            idx_d        = '0;
            best_valid_d = 1'b0;
            best_id_d    = '0;
            best_h_d     = my_best_h;
            best_qv_d    = my_best_q;
`ifdef BEST_NBR_SECOND_EN
            sec_valid_d  = 1'b0;
            sec_id_d     = '0;
            sec_h_d      = '0;
            sec_qv_d     = '0;
`endif
            state_d      = ST_RD_CNT;
          end
        end
        ST_RD_CNT: state_d = ST_CAP_CNT;
        ST_CAP_CNT: begin
          ptr_d = ptr_q + ADDR_W'(1);
          if (data_in > WORD_W'(MAX_NBRS)) begin
            count_d   = CNT_W'(MAX_NBRS);
            clamped_d = 1'b1;
          end else begin
            count_d   = data_in[CNT_W-1:0];
            clamped_d = 1'b0;
          end
          state_d = (data_in == '0) ? ST_DONE : ST_RD_ID;
        end
        ST_RD_ID: state_d = ST_CAP_ID;
        ST_CAP_ID: begin
          cand_id_d = data_in;
          ptr_d     = ptr_q + ADDR_W'(1);
          state_d   = ST_RD_HOP;
        end
        ST_RD_HOP: state_d = ST_CAP_HOP;
        ST_CAP_HOP: begin
          cand_h_d = data_in;
          ptr_d    = ptr_q + ADDR_W'(1);
          state_d  = ST_RD_Q;
        end
        ST_RD_Q: state_d = ST_CAP_Q;
        ST_CAP_Q: begin
          cand_q_d = data_in;
          ptr_d    = ptr_q + ADDR_W'(1);
          state_d  = ST_CMP;
        end
        ST_CMP: begin
          if (cand_id_q != node_id_q) begin
            if (beats_best) begin
`ifdef BEST_NBR_SECOND_EN
              // The displaced best (possibly the baseline, flagged invalid)
              // becomes the runner-up.
              sec_valid_d = best_valid_q;
              sec_id_d    = best_id_q;
              sec_h_d     = best_h_q;
              sec_qv_d    = best_qv_q;
`endif
              best_valid_d = 1'b1;
              best_id_d    = cand_id_q;
              best_h_d     = cand_h_q;
              best_qv_d    = cand_q_q;
            end
`ifdef BEST_NBR_SECOND_EN
            // An empty runner-up slot is filled by any non-winning neighbour.
            else if (!sec_valid_q || beats_second) begin
              sec_valid_d = 1'b1;
              sec_id_d    = cand_id_q;
              sec_h_d     = cand_h_q;
              sec_qv_d    = cand_q_q;
            end
`endif
          end
          idx_d   = idx_q + CNT_W'(1);
          state_d = (idx_d == count_q) ? ST_DONE : ST_RD_ID;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      last_addr_q  <= '0;
      mode_q       <= 1'b0;
      node_id_q    <= '0;
      idx_q        <= '0;
      count_q      <= '0;
      clamped_q    <= 1'b0;
      cand_id_q    <= '0;
      cand_h_q     <= '0;
      cand_q_q     <= '0;
      best_valid_q <= 1'b0;
      best_id_q    <= '0;
      best_h_q     <= '0;
      best_qv_q    <= '0;
`ifdef BEST_NBR_SECOND_EN
      sec_valid_q  <= 1'b0;
      sec_id_q     <= '0;
      sec_h_q      <= '0;
      sec_qv_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      last_addr_q  <= last_addr_d;
      mode_q       <= mode_d;
      node_id_q    <= node_id_d;
      idx_q        <= idx_d;
      count_q      <= count_d;
      clamped_q    <= clamped_d;
      cand_id_q    <= cand_id_d;
      cand_h_q     <= cand_h_d;
      cand_q_q     <= cand_q_d;
      best_valid_q <= best_valid_d;
      best_id_q    <= best_id_d;
      best_h_q     <= best_h_d;
      best_qv_q    <= best_qv_d;
`ifdef BEST_NBR_SECOND_EN
      sec_valid_q  <= sec_valid_d;
      sec_id_q     <= sec_id_d;
      sec_h_q      <= sec_h_d;
      sec_qv_q     <= sec_qv_d;
`endif
    end
  end

  assign best_valid  = best_valid_q;
  assign best_nbr_id = best_id_q;
  assign best_hop    = best_h_q;
  assign best_q      = best_qv_q;
  assign nbr_count   = count_q;
  assign cnt_clamped = clamped_q;
`ifdef BEST_NBR_SECOND_EN
  assign second_valid  = sec_valid_q;
  assign second_nbr_id = sec_id_q;
  assign second_hop    = sec_h_q;
  assign second_q      = sec_qv_q;
`endif

endmodule

// File: doc/best_neighbor_scan.md
Name: best_neighbor_scan

Overview:
Parametrised successor to the single-shot best-neighbour comparator in the EER-RL routing datapath. On `start`, it reads a neighbour table from node memory: a count word followed by {ID, hops, Q} triplets. It compares every entry against the node's own best (Q, hops) under a selectable ordering and reports the winning neighbour. It sits between the Q-update stage (which supplies my_best_q/my_best_h) and the packet-forwarding stage.

Parameters:
WORD_W, 16, width of data words, IDs, hops and Q values (Q unsigned fixed-point)
ADDR_W, 11, memory address width
MAX_NBRS, 32, maximum table entries scanned; larger counts are clamped

Ports:
clock  in  1  system clock, rising edge
nrst  in  1  asynchronous active-low reset
en  in  1  block enable; low forces IDLE (abort)
start  in  1  one-cycle scan request, sampled only in IDLE
mode  in  1  0 = Q-first ordering, 1 = hops-first ordering; latched at start
base_addr  in  ADDR_W  address of the count word; latched at start
node_id  in  WORD_W  own ID; entries with this ID are skipped
my_best_q  in  WORD_W  own best Q; initial comparison baseline
my_best_h  in  WORD_W  own best hops; initial comparison baseline
data_in  in  WORD_W  memory read data, valid 1 cycle after address/rd_en
address  out  ADDR_W  memory read address
rd_en  out  1  memory read strobe
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse, scan complete
best_valid  out  1  a neighbour beat the baseline
best_nbr_id  out  WORD_W  winning neighbour ID
best_hop  out  WORD_W  winning hops
best_q  out  WORD_W  winning Q
nbr_count  out  log2(MAX_NBRS)+1  number of entries scanned (after clamp)
cnt_clamped  out  1  table count exceeded MAX_NBRS

Behaviour:
- Reset: state IDLE; every output 0; internal pointer, index and latched inputs 0.
- States: IDLE, RD_CNT, CAP_CNT, RD_ID, CAP_ID, RD_HOP, CAP_HOP, RD_Q, CAP_Q, CMP, DONE.
- IDLE: when en&start, latch mode/base_addr/node_id/baseline; set best_q=my_best_q, best_hop=my_best_h, best_valid=0, best_nbr_id=0; go to RD_CNT.
- Each RD_x state: rd_en=1, address=pointer. The following CAP_x state captures data_in and advances pointer by 1. rd_en=0 and address holds its last value outside RD_x states.
- CAP_CNT: count=min(data_in, MAX_NBRS); cnt_clamped=(data_in>MAX_NBRS). If count=0, go to DONE; else go to RD_ID.
- CMP: if ID≠node_id and the candidate is strictly better than the current best, update best_*, best_valid=1. Increment index; if index==count, go to DONE, else go to RD_ID.
- Strictly better, mode 0: q>best_q, or (q==best_q and hops<best_hop). Mode 1: hops<best_hop, or (hops==best_hop and q>best_q). On a full tie the earlier entry is kept.
- DONE: done=1 for one cycle; go to IDLE. Results hold until the next accepted start.
- Latency: with start sampled at cycle 0, done is asserted at cycle 3+7·count (count=0 gives cycle 3).
- start while busy: ignored. en low in any state: return to IDLE next cycle, no done, results frozen, busy=0.
- Pointer arithmetic wraps modulo 2^ADDR_W. Compares are unsigned, full WORD_W width.
- Asynchronous reset mid-scan: immediate return to reset values.

Optional Feature:
BEST_NBR_SECOND_EN: when defined, adds outputs second_valid/second_nbr_id/second_hop/second_q.
- These track the runner-up under the same ordering: a displaced best shifts into second; a candidate better than second but not best replaces second.
- Reset/start values: second_* = 0.
- When undefined, these ports and their registers are absent; all other behaviour is identical.

Decomposition:
- Shared package best_nbr_pkg: state enum encoding, MODE_QFIRST/MODE_HFIRST constants, table layout offsets (CNT_OFS=0, ENTRY_WORDS=3).
- One sub-module nbr_better_cmp: combinational (mode, cand_q, cand_h, ref_q, ref_h) -> better. Instantiated once, or twice with BEST_NBR_SECOND_EN.

Test Plan:
- Count=0, start -> done at cycle 3, best_valid=0, best_q/best_hop equal the baseline.
- Mode 0, baseline Q=0x0100 H=3; entries {5,2,0x0200},{7,4,0x0300} -> best_nbr_id=7, best_q=0x0300, best_hop=4, done at cycle 17.
- Same table, mode 1 -> best_nbr_id=5, best_hop=2; an entry with ID==node_id and better values is skipped.
- Tie: entries {3,2,0x0200},{9,2,0x0200} -> best_nbr_id=3.
- Count word 40 with MAX_NBRS=32 -> cnt_clamped=1, nbr_count=32, done at cycle 227; en dropped mid-scan on a rerun -> IDLE, no done pulse.
- With BEST_NBR_SECOND_EN, the mode 0 table above -> second_nbr_id=5; asynchronous reset mid-scan -> all outputs 0 immediately.
